// File: rtl/trigger_manager_pkg.sv
// Shared types and default limits for the N-channel trigger manager.
package trigger_manager_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGo,
        StWaitDone,
        StPush
    } tm_state_e;

    localparam int unsigned DefNumChan      = 5;
    localparam int unsigned DefFillNumWidth = 24;
    localparam int unsigned DefGoPulseLen   = 4;
    localparam int unsigned DefTimeoutWidth = 16;
    localparam int unsigned DefDoneTimeout  = 50000;
    localparam int unsigned DefDropCntWidth = 16;

endpackage

// File: rtl/trigger_manager_nchan_if.sv
// Trigger, per-channel go/done, status and fill-number AXIS signals of the trigger manager.
interface trigger_manager_nchan_if #(
    parameter int unsigned NUM_CHAN       = trigger_manager_pkg::DefNumChan,
    parameter int unsigned FILL_NUM_WIDTH = trigger_manager_pkg::DefFillNumWidth,
    parameter int unsigned DROP_CNT_WIDTH = trigger_manager_pkg::DefDropCntWidth
);
    logic                      trigger;
    logic [NUM_CHAN-1:0]       chan_en;
    logic [NUM_CHAN-1:0]       done;
    logic                      clear_err;
    logic [NUM_CHAN-1:0]       go;
    logic                      fifo_valid;
    logic                      fifo_ready;
    logic [FILL_NUM_WIDTH-1:0] fifo_data;
    logic                      busy;
    logic                      timeout_err;
    logic [NUM_CHAN-1:0]       timed_out_mask;
    logic [DROP_CNT_WIDTH-1:0] drop_count;

    modport master (
        output trigger, chan_en, done, clear_err, fifo_ready,
        input  go, fifo_valid, fifo_data, busy, timeout_err, timed_out_mask, drop_count
    );

    modport slave (
        input  trigger, chan_en, done, clear_err, fifo_ready,
        output go, fifo_valid, fifo_data, busy, timeout_err, timed_out_mask, drop_count
    );
endinterface

// File: rtl/tm_done_collector.sv
// Sticky per-channel done tracking plus the done-timeout counter for one fill.
module tm_done_collector #(
    parameter int unsigned NUM_CHAN      = trigger_manager_pkg::DefNumChan,
    parameter int unsigned TIMEOUT_WIDTH = trigger_manager_pkg::DefTimeoutWidth,
    parameter int unsigned DONE_TIMEOUT  = trigger_manager_pkg::DefDoneTimeout
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clear,
    input  logic                i_collect,
    input  logic                i_count,
    input  logic [NUM_CHAN-1:0] i_done,
    input  logic [NUM_CHAN-1:0] i_mask,
    output logic                o_all_done,
    output logic                o_timed_out,
    output logic [NUM_CHAN-1:0] o_missing
);
    localparam logic [TIMEOUT_WIDTH-1:0] TimeoutLast = TIMEOUT_WIDTH'(DONE_TIMEOUT - 1);

    logic [NUM_CHAN-1:0]      r_done_seen;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic [NUM_CHAN-1:0]      w_seen_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_seen <= '0;
            r_timer     <= '0;
        end else begin
            if (i_clear) begin
                r_done_seen <= '0;
            end else if (i_collect) begin
                r_done_seen <= w_seen_now;
            end
            // Held at zero outside WAIT_DONE so each wait starts from a fresh count.
            r_timer <= i_count ? r_timer + 1'b1 : '0;
        end
    end

    assign w_seen_now  = r_done_seen | (i_done & i_mask);
    assign o_all_done  = (w_seen_now & i_mask) == i_mask;
    assign o_missing   = i_mask & ~w_seen_now;
    assign o_timed_out = (r_timer == TimeoutLast);
endmodule

// File: rtl/trigger_manager_nchan.sv
// Trigger manager: masked go pulses, done collection with timeout, fill-number push over AXIS.
module trigger_manager_nchan
    import trigger_manager_pkg::*;
#(
    parameter int unsigned NUM_CHAN       = DefNumChan,
    parameter int unsigned FILL_NUM_WIDTH = DefFillNumWidth,
    parameter int unsigned GO_PULSE_LEN   = DefGoPulseLen,
    parameter int unsigned TIMEOUT_WIDTH  = DefTimeoutWidth,
    parameter int unsigned DONE_TIMEOUT   = DefDoneTimeout,
    parameter int unsigned DROP_CNT_WIDTH = DefDropCntWidth
) (
    input  logic                    clk,
    input  logic                    rst_n,
    trigger_manager_nchan_if.slave  io_tm
);
    localparam int unsigned GoCntWidth = (GO_PULSE_LEN > 1) ? $clog2(GO_PULSE_LEN) : 1;
    localparam logic [GoCntWidth-1:0]     GoCntLast = GoCntWidth'(GO_PULSE_LEN - 1);
    localparam logic [FILL_NUM_WIDTH-1:0] FillMax   = {FILL_NUM_WIDTH{1'b1}};
    localparam logic [FILL_NUM_WIDTH-1:0] FillFirst = FILL_NUM_WIDTH'(1);

    tm_state_e                 r_state, w_state_d;
    logic [NUM_CHAN-1:0]       r_active_mask, w_active_mask_d;
    logic [NUM_CHAN-1:0]       r_go, w_go_d;
    logic [GoCntWidth-1:0]     r_go_cnt, w_go_cnt_d;
    logic                      r_fifo_valid, w_fifo_valid_d;
    logic [FILL_NUM_WIDTH-1:0] r_fill_num, w_fill_num_d;
    logic                      r_busy;
    logic                      r_timeout_err, w_timeout_err_d;
    logic [NUM_CHAN-1:0]       r_timed_out_mask, w_timed_out_mask_d;
    logic [DROP_CNT_WIDTH-1:0] r_drop_count, w_drop_count_d;

    logic                      w_accept, w_drop, w_collect, w_count;
    logic                      w_all_done, w_timed_out;
    logic [NUM_CHAN-1:0]       w_missing;

    assign w_accept  = (r_state == StIdle) && io_tm.trigger && (io_tm.chan_en != '0);
    assign w_drop    = io_tm.trigger && !w_accept;
    assign w_collect = (r_state == StGo) || (r_state == StWaitDone);
    assign w_count   = (r_state == StWaitDone);

    tm_done_collector #(
        .NUM_CHAN      (NUM_CHAN),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
        .DONE_TIMEOUT  (DONE_TIMEOUT)
    ) u_done_collector (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept),
        .i_collect   (w_collect),
        .i_count     (w_count),
        .i_done      (io_tm.done),
        .i_mask      (r_active_mask),
        .o_all_done  (w_all_done),
        .o_timed_out (w_timed_out),
        .o_missing   (w_missing)
    );

    always_comb begin
        w_state_d          = r_state;
        w_active_mask_d    = r_active_mask;
        w_go_d             = r_go;
        w_go_cnt_d         = r_go_cnt;
        w_fifo_valid_d     = r_fifo_valid;
        w_fill_num_d       = r_fill_num;
        w_timeout_err_d    = r_timeout_err;
        w_timed_out_mask_d = r_timed_out_mask;
        w_drop_count_d     = r_drop_count;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_active_mask_d = io_tm.chan_en;
                    w_go_d          = io_tm.chan_en;
                    w_go_cnt_d      = '0;
                    w_state_d       = StGo;
                end
            end
            StGo: begin
                if (r_go_cnt == GoCntLast) begin
                    w_go_d    = '0;
                    w_state_d = StWaitDone;
                end else begin
                    w_go_cnt_d = r_go_cnt + 1'b1;
                end
            end
            StWaitDone: begin
                // Completion is checked first so it beats a timeout landing on the same cycle.
                if (w_all_done) begin
                    w_fifo_valid_d = 1'b1;
                    w_state_d      = StPush;
                end else if (w_timed_out) begin
                    w_fifo_valid_d     = 1'b1;
                    w_timeout_err_d    = 1'b1;
                    w_timed_out_mask_d = r_timed_out_mask | w_missing;
                    w_state_d          = StPush;
                end
            end
            StPush: begin
                if (r_fifo_valid && io_tm.fifo_ready) begin
                    w_fifo_valid_d = 1'b0;
                    w_fill_num_d   = (r_fill_num == FillMax) ? FillFirst : r_fill_num + 1'b1;
                    w_state_d      = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_drop && (r_drop_count != {DROP_CNT_WIDTH{1'b1}})) begin
            w_drop_count_d = r_drop_count + 1'b1;
        end

        if (io_tm.clear_err) begin
            w_timeout_err_d    = 1'b0;
            w_timed_out_mask_d = '0;
            w_drop_count_d     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_active_mask    <= '0;
            r_go             <= '0;
            r_go_cnt         <= '0;
            r_fifo_valid     <= 1'b0;
            r_fill_num       <= FillFirst;
            r_busy           <= 1'b0;
            r_timeout_err    <= 1'b0;
            r_timed_out_mask <= '0;
            r_drop_count     <= '0;
        end else begin
            r_state          <= w_state_d;
            r_active_mask    <= w_active_mask_d;
            r_go             <= w_go_d;
            r_go_cnt         <= w_go_cnt_d;
            r_fifo_valid     <= w_fifo_valid_d;
            r_fill_num       <= w_fill_num_d;
            r_busy           <= (w_state_d != StIdle);
            r_timeout_err    <= w_timeout_err_d;
            r_timed_out_mask <= w_timed_out_mask_d;
            r_drop_count     <= w_drop_count_d;
        end
    end

    assign io_tm.go             = r_go;
    assign io_tm.fifo_valid     = r_fifo_valid;
    assign io_tm.fifo_data      = r_fill_num;
    assign io_tm.busy           = r_busy;
    assign io_tm.timeout_err    = r_timeout_err;
    assign io_tm.timed_out_mask = r_timed_out_mask;
    assign io_tm.drop_count     = r_drop_count;
endmodule

// File: tb/tb_trigger_manager_nchan.sv
// Bench for trigger_manager_nchan: directed fills checked against a per-cycle behavioural model.
module tb_trigger_manager_nchan;
    localparam int NC = 5;
    localparam int FW = 3;
    localparam int GL = 4;
    localparam int TO = 100;
    localparam int DW = 3;
    localparam int FILL_MAX = (1 << FW) - 1;
    localparam int DROP_MAX = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    trigger_manager_nchan_if #(.NUM_CHAN(NC), .FILL_NUM_WIDTH(FW), .DROP_CNT_WIDTH(DW)) tmif ();

    trigger_manager_nchan #(
        .NUM_CHAN       (NC),
        .FILL_NUM_WIDTH (FW),
        .GO_PULSE_LEN   (GL),
        .TIMEOUT_WIDTH  (16),
        .DONE_TIMEOUT   (TO),
        .DROP_CNT_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_tm (tmif)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pushed[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model of the outputs, updated on each edge from the inputs seen at that edge.
    bit       m_live = 0;
    bit       m_busy, m_valid, m_err;
    int       m_go_left, m_wait, m_fill, m_drop;
    logic [NC-1:0] m_mask, m_seen, m_tom, m_now;
    bit       m_dropped;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1; m_busy = 0; m_valid = 0; m_err = 0;
            m_go_left = 0; m_wait = 0; m_fill = 1; m_drop = 0;
            m_mask = '0; m_seen = '0; m_tom = '0;
        end else if (m_live) begin
            m_dropped = tmif.trigger && (m_busy || tmif.chan_en == '0);
            if (!m_busy) begin
                if (tmif.trigger && tmif.chan_en != '0) begin
                    m_mask = tmif.chan_en; m_seen = '0; m_go_left = GL; m_busy = 1;
                end
            end else if (m_go_left > 0) begin
                m_seen |= tmif.done & m_mask;
                m_go_left--;
                m_wait = 0;
            end else if (!m_valid) begin
                m_now = m_seen | (tmif.done & m_mask);
                if (m_now == m_mask) m_valid = 1;
                else if (m_wait == TO - 1) begin
                    m_valid = 1; m_err = 1; m_tom |= m_mask & ~m_now;
                end else m_wait++;
                m_seen = m_now;
            end else if (tmif.fifo_ready) begin
                m_valid = 0; m_busy = 0;
                m_fill = (m_fill == FILL_MAX) ? 1 : m_fill + 1;
            end
            if (m_dropped && m_drop != DROP_MAX) m_drop++;
            if (tmif.clear_err) begin
                m_err = 0; m_tom = '0; m_drop = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("go", 32'(tmif.go), 32'(m_go_left > 0 ? m_mask : '0));
            chk("fifo_valid", 32'(tmif.fifo_valid), 32'(m_valid));
            chk("fifo_data", 32'(tmif.fifo_data), m_fill);
            chk("busy", 32'(tmif.busy), 32'(m_busy));
            chk("timeout_err", 32'(tmif.timeout_err), 32'(m_err));
            chk("timed_out_mask", 32'(tmif.timed_out_mask), 32'(m_tom));
            chk("drop_count", 32'(tmif.drop_count), m_drop);
            if (rst_n && tmif.fifo_valid && tmif.fifo_ready) pushed.push_back(int'(tmif.fifo_data));
        end
    end

    task automatic pop_chk(input string name, input int exp);
        if (pushed.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no handshake seen, expected data %0d", name, exp);
        end else begin
            chk(name, pushed.pop_front(), exp);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (tmif.busy && n < 400) begin
            tick(1);
            n++;
        end
        chk(name, 32'(tmif.busy), 0);
    endtask

    task automatic run_fill(input logic [NC-1:0] en, input logic [NC-1:0] dn, input int dly,
                            input int exp);
        tmif.chan_en = en; tmif.fifo_ready = 1'b1; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        tick(GL);
        tick(dly);
        tmif.done = dn;
        wait_idle("fill_idle");
        tmif.done = '0;
        pop_chk("fill_data", exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        tmif.trigger = 1'b0; tmif.chan_en = '0; tmif.done = '0;
        tmif.clear_err = 1'b0; tmif.fifo_ready = 1'b0;
        tick(3);
        chk("rst_go", 32'(tmif.go), 0);
        chk("rst_data", 32'(tmif.fifo_data), 1);
        chk("rst_busy", 32'(tmif.busy), 0);
        rst_n = 1'b1;
        tick(1);

        // Basic fill, all channels.
        tmif.chan_en = 5'b11111; tmif.fifo_ready = 1'b1; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        for (int i = 0; i < GL; i++) begin
            chk("t1_go_on", 32'(tmif.go), 32'h1f);
            tick(1);
        end
        chk("t1_go_off", 32'(tmif.go), 0);
        tick(10);
        tmif.done = 5'b11111;
        wait_idle("t1_idle");
        tmif.done = '0;
        chk("t1_hs_count", pushed.size(), 1);
        pop_chk("t1_data", 1);
        chk("t1_err", 32'(tmif.timeout_err), 0);

        // Masked channels; done on inactive channels must not complete the fill.
        tmif.chan_en = 5'b00101; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        chk("t2_go", 32'(tmif.go), 32'h05);
        tick(GL);
        tmif.done = 5'b11010;
        tick(5);
        chk("t2_still_busy", 32'(tmif.busy), 1);
        chk("t2_no_valid", 32'(tmif.fifo_valid), 0);
        tmif.done = 5'b00101;
        wait_idle("t2_idle");
        tmif.done = '0;
        pop_chk("t2_data", 2);
        chk("t2_err", 32'(tmif.timeout_err), 0);

        // Timeout with channel 3 silent.
        tmif.fifo_ready = 1'b0; tmif.chan_en = 5'b11111; tmif.done = 5'b10111;
        tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        tick(GL);
        n = 0;
        while (!tmif.fifo_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk("t3_latency", n, 100);
        chk("t3_err", 32'(tmif.timeout_err), 1);
        chk("t3_mask", 32'(tmif.timed_out_mask), 32'h08);
        tmif.fifo_ready = 1'b1;
        tick(1);
        tmif.fifo_ready = 1'b0; tmif.done = '0;
        pop_chk("t3_data", 3);
        tmif.clear_err = 1'b1;
        tick(1);
        tmif.clear_err = 1'b0;
        chk("t3_err_clr", 32'(tmif.timeout_err), 0);
        chk("t3_mask_clr", 32'(tmif.timed_out_mask), 0);

        // Back-pressure with triggers arriving mid-fill, plus one empty-mask trigger.
        tmif.chan_en = 5'b11111; tmif.done = 5'b11111; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        tick(1);
        tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        n = 0;
        while (!tmif.fifo_valid && n < 50) begin
            tick(1);
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            tmif.trigger = (i == 3 || i == 9);
            tick(1);
            chk("t4_hold_valid", 32'(tmif.fifo_valid), 1);
            chk("t4_hold_data", 32'(tmif.fifo_data), 4);
        end
        tmif.trigger = 1'b0; tmif.fifo_ready = 1'b1;
        tick(1);
        tmif.fifo_ready = 1'b0; tmif.done = '0;
        pop_chk("t4_data", 4);
        tmif.chan_en = '0; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        chk("t4_drops", 32'(tmif.drop_count), 4);
        run_fill(5'b11111, 5'b11111, 2, 5);
        tmif.chan_en = '0; tmif.trigger = 1'b1;
        tick(5);
        tmif.trigger = 1'b0;
        chk("t4_drop_sat", 32'(tmif.drop_count), 7);
        tmif.clear_err = 1'b1; tmif.trigger = 1'b1;
        tick(1);
        tmif.clear_err = 1'b0; tmif.trigger = 1'b0;
        chk("t4_drop_clr", 32'(tmif.drop_count), 0);

        // Wrap of the 3-bit fill number; last fill completes on the timeout cycle.
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pushed.delete();
        for (int i = 0; i < 7; i++) run_fill(5'b11111, 5'b11111, i, i + 1);
        run_fill(5'b11111, 5'b11111, TO - 1, 1);
        chk("t5_no_err", 32'(tmif.timeout_err), 0);

        // Reset in WAIT_DONE abandons the fill.
        tmif.chan_en = 5'b11111; tmif.trigger = 1'b1;
        tick(1);
        tmif.trigger = 1'b0;
        tick(GL + 2);
        rst_n = 1'b0;
        tick(1);
        chk("t6_go", 32'(tmif.go), 0);
        chk("t6_valid", 32'(tmif.fifo_valid), 0);
        chk("t6_busy", 32'(tmif.busy), 0);
        rst_n = 1'b1;
        tick(1);
        run_fill(5'b11111, 5'b11111, 1, 1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
